// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg_if
//  Description : Receive-word handshake bundle between the UART receiver
//                (master) and its consumer (slave).
//                rx_data  - FIFO head data word
//                rx_perr  - parity error flag travelling with rx_data
//                rx_valid - FIFO non-empty
//                rx_ready - consumer accepts head when rx_valid & rx_ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_perr,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_perr,
        input  rx_valid,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cfg
//  Description : Parametrised UART receiver. 3-flop input synchroniser,
//                3-sample mid-bit majority vote, false-start rejection,
//                parity / framing / break detection and an output FIFO.
//  Ports       : clk, rst (async, active-high), rs232_rx (serial line),
//                rx_if (master: rx_data, rx_perr, rx_valid / rx_ready),
//                frame_err, break_det, overrun (1-cycle pulses), busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     rs232_rx,
    uart_rx_cfg_if.master rx_if,
    output logic          frame_err,
    output logic          break_det,
    output logic          overrun,
    output logic          busy
);

    localparam int c_baud_div = CLK_FREQ / BAUD;
    localparam int c_cnt_w    = $clog2(c_baud_div);
    localparam int c_mid      = c_baud_div / 2;
    localparam int c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam int c_word_w   = DATA_BITS + 1;

    localparam logic [c_cnt_w-1:0] c_cnt_smp0 = c_cnt_w'(c_mid - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_smp1 = c_cnt_w'(c_mid);
    localparam logic [c_cnt_w-1:0] c_cnt_res  = c_cnt_w'(c_mid + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_baud_div - 1);
    localparam logic [3:0]         c_data_bits = 4'(DATA_BITS);
    localparam logic [3:0]         c_stop_last = 4'(STOP_BITS - 1);
    localparam logic [c_ptr_w:0]   c_full     = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic               c_odd      = (PARITY == 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic                 r_sync1, r_sync2, r_sync3;
    logic [2:0]           r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_baud_cnt;
    logic                 r_smp0, r_smp1;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr, r_stop_err, r_all_zero, r_done;

    logic                 w_fall, w_resolve, w_wrap, w_maj;
    logic                 w_enter_start, w_take_data, w_take_par, w_take_stop, w_frame_end;

    logic [c_word_w-1:0]  r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_full, w_pop, w_good, w_push;

    // The line idles high, so the synchroniser resets to 1 to avoid a
    // spurious falling edge coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rs232_rx;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_fall    = ~r_sync2 & r_sync3;
    assign w_resolve = (r_baud_cnt == c_cnt_res);
    assign w_wrap    = (r_baud_cnt == c_cnt_last);
    // Third sample is the live r_sync2 on the resolution count.
    assign w_maj     = (r_smp0 & r_smp1) | (r_smp0 & r_sync2) | (r_smp1 & r_sync2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_enter_start = 1'b0;
        w_take_data   = 1'b0;
        w_take_par    = 1'b0;
        w_take_stop   = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt   = S_START;
                    w_enter_start = 1'b1;
                end
            end
            S_START: begin
                if (w_resolve && w_maj) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wrap) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_take_data = w_resolve;
                if (w_wrap && (r_bit_cnt == c_data_bits)) begin
                    w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                w_take_par = w_resolve;
                if (w_wrap) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_resolve) begin
                    w_take_stop = 1'b1;
                    // Last stop bit: leave at its mid-bit so a following
                    // start edge is never missed.
                    if (r_bit_cnt == c_stop_last) begin
                        w_frame_end = 1'b1;
                        w_state_nxt = (r_all_zero && !w_maj) ? S_WAIT_IDLE : S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_smp0     <= 1'b1;
            r_smp1     <= 1'b1;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_stop_err <= 1'b0;
            r_all_zero <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_enter_start || w_wrap) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            if (r_baud_cnt == c_cnt_smp0) r_smp0 <= r_sync2;
            if (r_baud_cnt == c_cnt_smp1) r_smp1 <= r_sync2;

            if (w_take_data || (w_take_stop && !w_frame_end)) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end

            if (w_enter_start) begin
                r_perr     <= 1'b0;
                r_stop_err <= 1'b0;
                r_all_zero <= 1'b1;
            end
            if (w_take_data) begin
                r_shift    <= {w_maj, r_shift[DATA_BITS-1:1]};
                r_all_zero <= r_all_zero & ~w_maj;
            end
            if (w_take_par) begin
                r_perr     <= ((^r_shift) ^ w_maj) != c_odd;
                r_all_zero <= r_all_zero & ~w_maj;
            end
            if (w_take_stop) begin
                r_all_zero <= r_all_zero & ~w_maj;
                if (!w_maj) r_stop_err <= 1'b1;
            end

            r_done <= w_frame_end;
        end
    end

    // Frame disposition, one cycle after the last stop bit resolves.
    assign w_pop  = rx_if.rx_valid & rx_if.rx_ready;
    assign w_full = (r_count == c_full);
    assign w_good = r_done & ~r_all_zero & ~r_stop_err;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push = w_good & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            break_det <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            break_det <= r_done & r_all_zero;
            frame_err <= r_done & ~r_all_zero & r_stop_err;
            overrun   <= w_good & w_full & ~w_pop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {r_perr, r_shift};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign {rx_if.rx_perr, rx_if.rx_data} = r_mem[r_rd_ptr];
    assign rx_if.rx_valid = (r_count != '0);
    assign busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_cfg
//  Description : Scoreboard bench for uart_rx_cfg. Three receivers share
//                one clock: 8N1, 8E1 and 9N2, all at 16 clocks per bit with
//                a 4-entry FIFO. Frames are built bit by bit from a frame
//                description; the expected outcome is decided from the
//                frame contents and pushed before the frame is driven.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

    localparam int c_bit_clks = 16;

    typedef struct packed {
        logic [1:0] id;
        logic       perr;
        logic [8:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] line;
    logic       rdy;
    wire  [2:0] ferr, brk, ovr, busy;
    wire  [2:0] vld;
    wire  [2:0] mperr;
    logic [8:0] mdat [3];

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   obs_ferr[3], obs_brk[3], obs_ovr[3];
    int   exp_ferr[3], exp_brk[3], exp_ovr[3];

    always #5 clk = ~clk;

    uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
    uart_rx_cfg_if #(.DATA_BITS(9)) if2 ();

    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .rst(rst), .rs232_rx(line[0]), .rx_if(if0.master),
        .frame_err(ferr[0]), .break_det(brk[0]), .overrun(ovr[0]), .busy(busy[0]));
    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .rs232_rx(line[1]), .rx_if(if1.master),
        .frame_err(ferr[1]), .break_det(brk[1]), .overrun(ovr[1]), .busy(busy[1]));
    uart_rx_cfg #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(9), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .rs232_rx(line[2]), .rx_if(if2.master),
        .frame_err(ferr[2]), .break_det(brk[2]), .overrun(ovr[2]), .busy(busy[2]));

    assign if0.rx_ready = rdy;
    assign if1.rx_ready = rdy;
    assign if2.rx_ready = rdy;
    assign vld   = {if2.rx_valid, if1.rx_valid, if0.rx_valid};
    assign mperr = {if2.rx_perr, if1.rx_perr, if0.rx_perr};
    assign mdat[0] = {1'b0, if0.rx_data};
    assign mdat[1] = {1'b0, if1.rx_data};
    assign mdat[2] = if2.rx_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a receiver hands over a word,
    // and tallies the error pulses of every receiver.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (vld[k] && rdy) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL spurious_word: dut%0d gave 0x%0h, expected no word", k, mdat[k]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("rx_dut_id", k, e.id);
                        check("rx_data", mdat[k], e.data);
                        check("rx_perr", mperr[k], e.perr);
                    end
                end
                if (ferr[k]) obs_ferr[k]++;
                if (brk[k])  obs_brk[k]++;
                if (ovr[k])  obs_ovr[k]++;
            end
        end
    end

    // Change rdy just after a rising edge so the monitor (negedge) and the
    // DUT (next rising edge) agree on its value.
    task automatic set_rdy(input logic v);
        @(posedge clk);
        #1 rdy = v;
        @(negedge clk);
    endtask

    task automatic idle(input int id, input int cycles);
        line[id] = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    // Drives one frame on receiver id. stop_v gives the stop bit values,
    // glitch_pos inverts one clock in the middle of that frame bit,
    // abort_pos returns half-way through that frame bit (no outcome modelled).
    task automatic send(input int id, input logic [8:0] data_in, input logic par_bit,
                        input logic [1:0] stop_v, input int glitch_pos, input int abort_pos);
        int          nb, nstop, n, ones;
        logic        has_par, stop_bad, all0, perr;
        logic [8:0]  data;
        logic [15:0] fr;
        exp_t        e;
        nb      = (id == 2) ? 9 : 8;
        nstop   = (id == 2) ? 2 : 1;
        has_par = (id == 1);
        data    = (nb == 9) ? data_in : {1'b0, data_in[7:0]};
        fr      = '0;
        n       = 1;
        stop_bad = 1'b0;
        for (int i = 0; i < nb; i++) begin
            fr[n] = data[i];
            n++;
        end
        if (has_par) begin
            fr[n] = par_bit;
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            fr[n] = stop_v[i];
            if (!stop_v[i]) stop_bad = 1'b1;
            n++;
        end
        all0 = (fr == 16'h0);
        ones = $countones(data) + int'(par_bit);
        perr = has_par && ((ones % 2) != 0);
        if (abort_pos < 0) begin
            if (all0)                             exp_brk[id]++;
            else if (stop_bad)                    exp_ferr[id]++;
            else if (!rdy && exp_q.size() >= 4)   exp_ovr[id]++;
            else begin
                e.id   = 2'(id);
                e.perr = perr;
                e.data = data;
                exp_q.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < c_bit_clks; c++) begin
                if (i == abort_pos && c == 8) return;
                line[id] = (i == glitch_pos && c == 8) ? ~fr[i] : fr[i];
                @(negedge clk);
            end
        end
    endtask

    task automatic check_counts(input int id);
        check("frame_err_count", obs_ferr[id], exp_ferr[id]);
        check("break_det_count", obs_brk[id], exp_brk[id]);
        check("overrun_count", obs_ovr[id], exp_ovr[id]);
        check("words_outstanding", exp_q.size(), 0);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(negedge clk);
        check("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        int   cyc;
        logic seen;
        logic [1:0] sv;
        for (int k = 0; k < 3; k++) begin
            obs_ferr[k] = 0; obs_brk[k] = 0; obs_ovr[k] = 0;
            exp_ferr[k] = 0; exp_brk[k] = 0; exp_ovr[k] = 0;
        end
        rst  = 1'b1;
        line = 3'b111;
        rdy  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {29'd0, busy}, 0);
        check("reset_valid", {29'd0, vld}, 0);
        check("reset_pulses", {23'd0, ferr, brk, ovr}, 0);
        check("reset_rx_data", mdat[0], 0);
        check("reset_rx_perr", {29'd0, mperr}, 0);
        rst = 1'b0;
        idle(0, 10);

        // Single word, consumer ready.
        set_rdy(1'b1);
        send(0, 9'h0A5, 1'b0, 2'b11, -1, -1);
        idle(0, 40);
        check_counts(0);

        // Five back-to-back frames into a 4-deep FIFO with the consumer stalled.
        set_rdy(1'b0);
        send(0, 9'h055, 1'b0, 2'b11, -1, -1);
        send(0, 9'h00F, 1'b0, 2'b11, -1, -1);
        send(0, 9'h0F0, 1'b0, 2'b11, -1, -1);
        send(0, 9'h081, 1'b0, 2'b11, -1, -1);
        send(0, 9'h07E, 1'b0, 2'b11, -1, -1);
        idle(0, 40);
        check("full_valid", vld[0], 1'b1);
        check("full_head", mdat[0], 9'h055);
        check("overrun_count", obs_ovr[0], exp_ovr[0]);
        set_rdy(1'b1);
        wait_drain();
        idle(0, 10);
        check("drained_valid", vld[0], 1'b0);

        // Even parity: 0x03 has two ones, so parity bit 1 is an error.
        send(1, 9'h003, 1'b1, 2'b11, -1, -1);
        idle(1, 30);
        send(1, 9'h003, 1'b0, 2'b11, -1, -1);
        idle(1, 40);
        check_counts(1);

        // Framing error, then a long break, then normal traffic.
        send(0, 9'h03C, 1'b0, 2'b10, -1, -1);
        idle(0, 40);
        send(0, 9'h000, 1'b0, 2'b10, -1, -1);
        line[0] = 1'b0;
        repeat (2 * c_bit_clks) @(negedge clk);
        idle(0, 40);
        send(0, 9'h011, 1'b0, 2'b11, -1, -1);
        idle(0, 40);
        check_counts(0);

        // Short low glitch on the idle line is rejected as a false start.
        line[0] = 1'b0;
        repeat (4) @(negedge clk);
        seen = busy[0];
        line[0] = 1'b1;
        cyc = 0;
        while (busy[0] && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        check("glitch_busy_seen", seen, 1'b1);
        check("glitch_busy_clear", busy[0], 1'b0);
        idle(0, 40);
        check_counts(0);
        // One-clock spike in the middle of data bit 3 is voted out.
        send(0, 9'h000, 1'b0, 2'b11, 4, -1);
        idle(0, 40);
        check_counts(0);

        // 9 data bits, 2 stop bits.
        send(2, 9'h1AB, 1'b0, 2'b11, -1, -1);
        idle(2, 40);
        check_counts(2);
        // Reset in the middle of a frame flushes the FIFO.
        set_rdy(1'b0);
        send(2, 9'h0F5, 1'b0, 2'b11, -1, -1);
        idle(2, 40);
        check("held_valid", vld[2], 1'b1);
        send(2, 9'h155, 1'b0, 2'b11, -1, 5);
        check("midframe_busy", busy[2], 1'b1);
        rst = 1'b1;
        #1;
        check("rst_busy", busy[2], 1'b0);
        check("rst_valid", vld[2], 1'b0);
        void'(exp_q.pop_back());
        line[2] = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        set_rdy(1'b1);
        idle(2, 20);
        send(2, 9'h042, 1'b0, 2'b11, -1, -1);
        idle(2, 40);
        check_counts(2);

        // Randomised traffic on all three receivers, consumer always ready.
        for (int r = 0; r < 90; r++) begin
            int id;
            logic [8:0] d;
            logic bad;
            id = (r < 40) ? 0 : ((r < 65) ? 1 : 2);
            d  = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 15) == 0) d = 9'h000;
            sv = 2'b11;
            if ($urandom_range(0, 7) == 0) sv[0] = 1'b0;
            if (id == 2 && $urandom_range(0, 7) == 0) sv[1] = 1'b0;
            bad = (id == 2) ? (sv != 2'b11) : !sv[0];
            send(id, d, 1'($urandom_range(0, 1)), sv, -1, -1);
            // A frame ending low needs the line to return high before the
            // next start edge can exist.
            idle(id, bad ? 40 : int'($urandom_range(0, 30)));
        end
        idle(0, 60);
        wait_drain();
        for (int k = 0; k < 3; k++) check_counts(k);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
